// File: rtl/conv_bias_relu_stage_if.sv
// Accumulator-in / activation-out stream plus the side port to the bias ROM.
interface conv_bias_relu_stage_if #(parameter int ACC_W = 24);
  logic                    acc_valid;
  logic                    acc_ready;
  logic signed [ACC_W-1:0] acc_data;
  logic                    acc_sop;
  logic [15:0]             bias_row;
  logic [15:0]             bias_col;
  logic signed [7:0]       bias_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [7:0]       out_data;
  logic [5:0]              out_ch;
  logic                    out_last;
  logic                    sync_err;

  modport slave (
    input  acc_valid, acc_data, acc_sop, bias_data, out_ready,
    output acc_ready, bias_row, bias_col, out_valid, out_data, out_ch, out_last, sync_err
  );

  modport master (
    output acc_valid, acc_data, acc_sop, bias_data, out_ready,
    input  acc_ready, bias_row, bias_col, out_valid, out_data, out_ch, out_last, sync_err
  );
endinterface

// File: rtl/conv_bias_relu_stage.sv
// Two-stage post-conv stage: S1 adds per-channel bias, S2 rounds Q.14 -> Q1.7,
// saturates and optionally applies ReLU. One advance enable drives the whole pipe.
module conv_bias_relu_stage #(
  parameter int NUM_CH     = 64,
  parameter int ACC_W      = 24,
  parameter int FRAC_SHIFT = 7,
  parameter int RELU_EN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  conv_bias_relu_stage_if.slave bus
);
  localparam int STAGES = 2;
  localparam int W1 = ACC_W + 1;
  localparam int W2 = ACC_W + 2;
  localparam logic [5:0] LAST_CH = 6'(NUM_CH - 1);
  localparam logic signed [W2-1:0] HALF  = W2'(2 ** (FRAC_SHIFT - 1));
  localparam logic signed [W2-1:0] R_MAX = W2'(127);
  localparam logic signed [W2-1:0] R_MIN = -(W2'(128));

  logic [STAGES:1]        vld_pipe;
  logic                   en, xfer;
  logic [5:0]             ch_cnt, eff_ch, s1_ch;
  logic                   s1_last;
  logic signed [W1-1:0]   sum, s1_sum;
  logic signed [W2-1:0]   rnd;
  logic signed [7:0]      act;
  logic signed [7:0]      out_data_q;
  logic [5:0]             out_ch_q;
  logic                   out_last_q, sync_err_q;

  assign en     = !vld_pipe[2] || bus.out_ready;
  assign xfer   = bus.acc_valid && en;
  // A sop beat always restarts at channel 0, even if the counter disagrees.
  assign eff_ch = bus.acc_sop ? 6'd0 : ch_cnt;

  assign bus.acc_ready = en;
  assign bus.bias_row  = {10'd0, eff_ch};
  assign bus.bias_col  = 16'd0;
  assign bus.out_valid = vld_pipe[2];
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
  assign bus.sync_err  = sync_err_q;

  // Bias is Q1.7; shifting by 7 aligns it to the Q.14 accumulator.
  assign sum = W1'(bus.acc_data) + W1'($signed({bus.bias_data, 7'd0}));

  always_comb begin
    rnd = (W2'(s1_sum) + HALF) >>> FRAC_SHIFT;
    act = rnd[7:0];
    if (rnd > R_MAX)      act = 8'sd127;
    else if (rnd < R_MIN) act = -8'sd128;
    if (RELU_EN != 0 && act < 0) act = 8'sd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      ch_cnt     <= '0;
      s1_sum     <= '0;
      s1_ch      <= '0;
      s1_last    <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_last_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      if (xfer && bus.acc_sop && ch_cnt != 6'd0) sync_err_q <= 1'b1;
      if (en) begin
        vld_pipe <= {vld_pipe[1], xfer};
        if (xfer) begin
          s1_sum  <= sum;
          s1_ch   <= eff_ch;
          s1_last <= (eff_ch == LAST_CH);
          ch_cnt  <= (eff_ch == LAST_CH) ? 6'd0 : eff_ch + 6'd1;
        end
        out_data_q <= act;
        out_ch_q   <= s1_ch;
        out_last_q <= s1_last;
      end
    end
  end
endmodule

// File: tb/tb_conv_bias_relu_stage.sv
// Scoreboard bench: two DUTs (ReLU on / off) share one stimulus stream.
module tb_conv_bias_relu_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_valid = 1'b0, acc_sop = 1'b0, out_ready = 1'b1;
  logic signed [23:0] acc_data = '0;
  always #5 clk = ~clk;

  conv_bias_relu_stage_if #(.ACC_W(24)) if1 (), if0 ();

  function automatic logic signed [7:0] bias_of(input int ch);
    case (ch)
      0:  return -8'sd39;
      1:  return 8'sd33;
      8:  return 8'sd0;
      39: return 8'sd68;
      default: return 8'(ch * 5 - 100);
    endcase
  endfunction

  function automatic logic signed [7:0] model(input longint acc, input int bias, input bit relu);
    longint s, r;
    s = acc + longint'(bias) * 128;
    r = (s + 64) >>> 7;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return 8'(r);
  endfunction

  assign if1.acc_valid = acc_valid;
  assign if1.acc_data  = acc_data;
  assign if1.acc_sop   = acc_sop;
  assign if1.out_ready = out_ready;
  assign if1.bias_data = bias_of(int'(if1.bias_row));
  assign if0.acc_valid = acc_valid;
  assign if0.acc_data  = acc_data;
  assign if0.acc_sop   = acc_sop;
  assign if0.out_ready = out_ready;
  assign if0.bias_data = bias_of(int'(if0.bias_row));

  conv_bias_relu_stage #(.RELU_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  conv_bias_relu_stage #(.RELU_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  typedef struct {
    logic signed [7:0] d1;
    logic signed [7:0] d0;
    logic [5:0]        ch;
    logic              last;
    bit                lat;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, cyc = 0, m_ch = 0;
  bit   lat_chk = 0, m_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && if1.out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got ch=%0d data=%0d, required no output", if1.out_ch, if1.out_data);
      end else begin
        mon_e = sb.pop_front();
        if (if1.out_data !== mon_e.d1) begin
          fails++;
          $display("FAIL data_relu ch=%0d: got %0d, required %0d", mon_e.ch, if1.out_data, mon_e.d1);
        end
        tests++;
        if (if0.out_data !== mon_e.d0) begin
          fails++;
          $display("FAIL data_norelu ch=%0d: got %0d, required %0d", mon_e.ch, if0.out_data, mon_e.d0);
        end
        tests++;
        if (if1.out_ch !== mon_e.ch) begin
          fails++;
          $display("FAIL out_ch: got %0d, required %0d", if1.out_ch, mon_e.ch);
        end
        tests++;
        if (if1.out_last !== mon_e.last) begin
          fails++;
          $display("FAIL out_last ch=%0d: got %b, required %b", mon_e.ch, if1.out_last, mon_e.last);
        end
        if (mon_e.lat) begin
          tests++;
          if (cyc !== mon_e.cyc + 2) begin
            fails++;
            $display("FAIL latency ch=%0d: got %0d cycles, required 2", mon_e.ch, cyc - mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic send_beat(input logic signed [23:0] a, input bit sop);
    exp_t e;
    int eff;
    bit ok;
    acc_valid = 1'b1; acc_data = a; acc_sop = sop; ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if1.acc_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got acc_ready=0 for 100 cycles, required 1");
    end else begin
      eff = sop ? 0 : m_ch;
      if (sop && m_ch != 0) m_err = 1;
      e.d1 = model(longint'(a), int'(bias_of(eff)), 1'b1);
      e.d0 = model(longint'(a), int'(bias_of(eff)), 1'b0);
      e.ch = 6'(eff);
      e.last = (eff == 63);
      e.lat = lat_chk;
      e.cyc = cyc;
      sb.push_back(e);
      m_ch = (eff == 63) ? 0 : eff + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    acc_valid = 1'b0; acc_sop = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !if1.out_valid) break;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
    end
    tests++;
    if (if1.sync_err !== m_err) begin
      fails++;
      $display("FAIL sync_err: got %b, required %b", if1.sync_err, m_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    sb.delete(); m_ch = 0; m_err = 0;
    tests++;
    if (if1.acc_ready !== 1'b1 || if1.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: got ready=%b valid=%b, required 1 0", if1.acc_ready, if1.out_valid);
    end
    tests++;
    if (if1.out_data !== 8'sd0 || if1.out_ch !== 6'd0 || if1.out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: got data=%0d ch=%0d last=%b, required 0 0 0", if1.out_data, if1.out_ch, if1.out_last);
    end
    tests++;
    if (if1.sync_err !== 1'b0 || if1.bias_row !== 16'd0) begin
      fails++;
      $display("FAIL reset_misc: got sync_err=%b bias_row=%0d, required 0 0", if1.sync_err, if1.bias_row);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (if1.bias_col !== 16'd0) begin
      fails++;
      $display("FAIL bias_col: got %0d, required 0", if1.bias_col);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    lat_chk = 1;
    send_beat(24'sd0, 1'b1);
    idle();
    @(negedge clk); @(negedge clk);
    tests++;
    if (if1.out_valid !== 1'b1 || if1.out_data !== 8'sd0 || if0.out_data !== -8'sd39 || if1.out_ch !== 6'd0) begin
      fails++;
      $display("FAIL basic_ch0: got v=%b relu=%0d norelu=%0d ch=%0d, required 1 0 -39 0",
               if1.out_valid, if1.out_data, if0.out_data, if1.out_ch);
    end
    drain();
  endtask

  task automatic test_stream();
    apply_reset();
    lat_chk = 1;
    for (int c = 0; c < 64; c++) send_beat(24'sd0, c == 0);
    drain();
  endtask

  task automatic test_round();
    logic signed [23:0] a1 [3];
    logic signed [23:0] a8 [3];
    logic signed [23:0] a;
    a1[0] = 24'sd4194304; a1[1] = -24'sd8388608; a1[2] = 24'sd100;
    a8[0] = 24'sd192;     a8[1] = 24'sd191;      a8[2] = -24'sd64;
    apply_reset();
    lat_chk = 1;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 64; c++) begin
        if (c == 1)      a = a1[p];
        else if (c == 8) a = a8[p];
        else             a = 24'(int'($urandom_range(0, 40000)) - 20000);
        send_beat(a, c == 0);
      end
    drain();
  endtask

  task automatic test_stall();
    logic signed [7:0] cap_d;
    logic [5:0] cap_ch;
    apply_reset();
    lat_chk = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_beat(24'(int'($urandom_range(0, 60000)) - 30000), i == 0);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        cap_d = if1.out_data; cap_ch = if1.out_ch;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          tests++;
          if (if1.acc_ready !== 1'b0 || if1.out_valid !== 1'b1 || if1.out_data !== cap_d || if1.out_ch !== cap_ch) begin
            fails++;
            $display("FAIL stall_hold: got ready=%b v=%b d=%0d ch=%0d, required 0 1 %0d %0d",
                     if1.acc_ready, if1.out_valid, if1.out_data, if1.out_ch, cap_d, cap_ch);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_sync();
    apply_reset();
    lat_chk = 1;
    for (int i = 0; i < 10; i++) send_beat(24'(int'($urandom_range(0, 20000)) - 10000), i == 0);
    tests++;
    if (if1.sync_err !== 1'b0) begin
      fails++;
      $display("FAIL sync_early: got %b, required 0", if1.sync_err);
    end
    send_beat(24'sd1000, 1'b1);
    tests++;
    if (if1.sync_err !== 1'b1) begin
      fails++;
      $display("FAIL sync_set: got %b, required 1", if1.sync_err);
    end
    for (int i = 0; i < 5; i++) send_beat(24'(int'($urandom_range(0, 20000)) - 10000), 1'b0);
    apply_reset();
    send_beat(24'sd5000, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_round();
    test_stall();
    test_sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end
endmodule

// File: doc/conv_bias_relu_stage.md
CONV_BIAS_RELU_STAGE -- requirements
Module: conv_bias_relu_stage

Interface
REQ-001 Parameter NUM_CH, default 64, output channels per pixel; channel index wraps at NUM_CH-1.
REQ-002 Parameter ACC_W, default 24, signed accumulator width, Q.14 (sum of Q1.7 x Q1.7 products).
REQ-003 Parameter FRAC_SHIFT, default 7, right shift from Q.14 to the Q1.7 output.
REQ-004 Parameter RELU_EN, default 1; 1 = clamp negatives to 0, 0 = pass signed result.
REQ-005 One clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 acc_valid  input  1  accumulator beat valid.
REQ-009 acc_ready  output  1  stage accepts a beat this cycle.
REQ-010 acc_data  input  ACC_W  signed accumulator for the current channel.
REQ-011 acc_sop  input  1  beat is channel 0 of a new pixel.
REQ-012 bias_row  output  16  bias ROM row address = current channel, zero-extended.
REQ-013 bias_col  output  16  bias ROM column address, constant 0.
REQ-014 bias_data  input  8  signed Q1.7 bias from the combinational bias ROM.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_data  output  8  signed Q1.7 activation.
REQ-018 out_ch  output  6  channel index of out_data.
REQ-019 out_last  output  1  out_ch == NUM_CH-1.
REQ-020 sync_err  output  1  sticky; acc_sop seen with the channel counter nonzero.

Function
REQ-021 Two-stage pipeline (S1: bias add; S2: round/saturate/ReLU) with one shared advance enable en = !out_valid || out_ready.
REQ-022 acc_ready = en; a beat transfers when acc_valid && acc_ready.
REQ-023 Latency: an accepted beat appears on out_* exactly 2 cycles later when out_ready is held high; throughput is 1 beat/cycle.
REQ-024 Stall: while en = 0, both stages and the channel counter hold, and out_* stay stable.
REQ-025 Pipeline bubbles: when en = 1 and no beat transfers, S1 valid is cleared; S2 takes S1 contents, so out_valid goes low after the pipe drains.
REQ-026 Channel counter ch_cnt, 6 bits, increments on each transfer and wraps NUM_CH-1 -> 0.
REQ-027 Effective channel of a transferring beat is 0 if acc_sop = 1, otherwise ch_cnt; after a sop beat, ch_cnt becomes 1.
REQ-028 bias_row is driven combinationally from the effective channel; bias_data is sampled into S1 in the same cycle as the transfer.
REQ-029 S1 sum = sign-extend(acc_data) + (sign-extend(bias_data) << 7), ACC_W+1 bits, never overflowing.
REQ-030 S2 rounding: r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (arithmetic shift, i.e. round half up).
REQ-031 S2 saturation: r > 127 -> 127; r < -128 -> -128.
REQ-032 S2 ReLU, when RELU_EN = 1: a negative saturated result becomes 0.
REQ-033 Channel index and last flag travel through the pipe alongside the data.
REQ-034 sync_err is set when acc_sop = 1 on a transfer and ch_cnt != 0; it clears only on reset; data processing is unaffected.
REQ-035 A transfer that coincides with a stall cannot occur, because acc_ready = 0 during a stall.

Reset
REQ-036 rst_n low asynchronously clears out_valid, out_data, out_ch, out_last, sync_err, ch_cnt and both stage valid bits to 0.
REQ-037 During reset, acc_ready = 1 (out_valid = 0) and bias_row = 0.
REQ-038 Reset asserted mid-pixel discards in-flight beats; the first post-reset beat is channel 0 regardless of acc_sop.

Verification
REQ-039 Beat acc = 0 with sop at ch0 (bias -39): sum = -4992, r = -39 -> out_data = 0 (RELU_EN = 1), or -39 (RELU_EN = 0), out_ch = 0.
REQ-040 Streamed acc = 0 for ch0..63 with out_ready = 1: ch39 (bias 68) -> 68; out_last is high only on out_ch = 63; out_valid is continuous 2 cycles after the first beat.
REQ-041 ch8 (bias 0): acc = 192 -> 2; acc = 191 -> 1; acc = -64 -> 0 (RELU_EN = 0 gives r = 0).
REQ-042 ch1 (bias 33), acc = 4194304 -> 127; acc = -8388608 with RELU_EN = 0 -> -128.
REQ-043 out_ready held low 5 cycles mid-stream: acc_ready low, out_* stable; after release there is no loss or duplication, and channels stay in order.
REQ-044 sop at ch_cnt = 10 -> sync_err = 1 and that beat is ch0; a later rst_n pulse clears sync_err and out_valid.
